// File: rtl/noc_node_ni.sv
// Network interface joining NUM_CH local valid/ready channels to one mesh router port.
// Optional macro NOC_NI_STATS_EN adds 32-bit injected/delivered flit counters.
module noc_node_ni #(
    parameter int NUM_CH    = 2,
    parameter int FLIT_W    = 64,
    parameter int NODE_W    = 2,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int PAYLOAD_W = FLIT_W - NODE_W - CH_W,
    parameter int RX_DEPTH  = 4,
    parameter int NODE_ID   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*PAYLOAD_W-1:0]   tx_data_i,
    input  logic [NUM_CH*NODE_W-1:0]      tx_dest_i,
    input  logic [NUM_CH-1:0]             tx_valid_i,
    output logic [NUM_CH-1:0]             tx_ready_o,
    output logic [NUM_CH*PAYLOAD_W-1:0]   rx_data_o,
    output logic [NUM_CH-1:0]             rx_valid_o,
    input  logic [NUM_CH-1:0]             rx_ready_i,
    output logic [FLIT_W-1:0]             noc_data_o,
    output logic                          noc_valid_o,
    input  logic                          noc_ready_i,
    input  logic [FLIT_W-1:0]             noc_data_i,
    input  logic                          noc_valid_i,
    output logic                          noc_ready_o,
    output logic [15:0]                   drop_cnt_o,
    output logic [31:0]                   tx_cnt_o,
    output logic [31:0]                   rx_cnt_o
);

    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    logic [CH_W-1:0]      ptr_q, ptr_d;
    logic [FLIT_W-1:0]    noc_data_q, noc_data_d;
    logic                 noc_valid_q, noc_valid_d;
    logic [CH_W-1:0]      grant_c;
    logic                 found_c, can_load_c, load_c;
    logic [PAYLOAD_W-1:0] sel_data_c;
    logic [NODE_W-1:0]    sel_dest_c;

    // Round-robin search from ptr upward; stage reloads whenever it is empty or draining.
    always_comb begin
        grant_c    = ptr_q;
        found_c    = 1'b0;
        sel_data_c = '0;
        sel_dest_c = '0;
        tx_ready_o = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found_c && tx_valid_i[(int'(ptr_q) + k) % NUM_CH]) begin
                found_c = 1'b1;
                grant_c = CH_W'((int'(ptr_q) + k) % NUM_CH);
            end
        end
        can_load_c = !noc_valid_q || noc_ready_i;
        load_c     = can_load_c && found_c;
        for (int i = 0; i < NUM_CH; i++) begin
            tx_ready_o[i] = can_load_c && (grant_c == CH_W'(i));
            if (grant_c == CH_W'(i)) begin
                sel_data_c = tx_data_i[i*PAYLOAD_W +: PAYLOAD_W];
                sel_dest_c = tx_dest_i[i*NODE_W +: NODE_W];
            end
        end
        ptr_d       = ptr_q;
        noc_data_d  = noc_data_q;
        noc_valid_d = noc_valid_q && !noc_ready_i;
        if (load_c) begin
            noc_data_d  = {sel_dest_c, grant_c, sel_data_c};
            noc_valid_d = 1'b1;
            ptr_d       = (grant_c == CH_W'(NUM_CH - 1)) ? '0 : grant_c + CH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            noc_data_q  <= '0;
            noc_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            noc_data_q  <= noc_data_d;
            noc_valid_q <= noc_valid_d;
        end
    end

    assign noc_data_o  = noc_data_q;
    assign noc_valid_o = noc_valid_q;

    logic [FLIT_W-1:0]    mem_q [RX_DEPTH];
    logic [FLIT_W-1:0]    mem_d [RX_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [15:0]          drop_q, drop_d;
    logic [FLIT_W-1:0]    head_c;
    logic [NODE_W-1:0]    head_dest_c;
    logic [CH_W-1:0]      head_ch_c;
    logic                 not_empty_c, ch_ok_c, head_ok_c, head_rdy_c, push_c, pop_c;

    assign noc_ready_o = (count_q != CW'(RX_DEPTH));

    // Head flit is either delivered to its channel or silently dropped; it blocks until then.
    always_comb begin
        head_c      = mem_q[rd_ptr_q];
        head_dest_c = head_c[FLIT_W-1 -: NODE_W];
        head_ch_c   = head_c[PAYLOAD_W +: CH_W];
        not_empty_c = (count_q != '0);
        ch_ok_c     = 1'b0;
        head_rdy_c  = 1'b0;
        rx_valid_o  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (head_ch_c == CH_W'(i)) begin
                ch_ok_c    = 1'b1;
                head_rdy_c = rx_ready_i[i];
            end
        end
        head_ok_c = ch_ok_c && (head_dest_c == NODE_W'(NODE_ID));
        for (int i = 0; i < NUM_CH; i++) begin
            rx_valid_o[i] = not_empty_c && head_ok_c && (head_ch_c == CH_W'(i));
        end
        rx_data_o = {NUM_CH{head_c[PAYLOAD_W-1:0]}};
        push_c    = noc_valid_i && noc_ready_o;
        pop_c     = not_empty_c && (!head_ok_c || head_rdy_c);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        drop_d    = drop_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = noc_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CW'(1);
        end
        if (pop_c && !head_ok_c && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RX_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    assign drop_cnt_o = drop_q;

`ifdef NOC_NI_STATS_EN
    logic [31:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    always_comb begin
        tx_cnt_d = tx_cnt_q + ((noc_valid_q && noc_ready_i) ? 32'd1 : 32'd0);
        rx_cnt_d = rx_cnt_q + ((pop_c && head_ok_c) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    assign tx_cnt_o = tx_cnt_q;
    assign rx_cnt_o = rx_cnt_q;
`else
    assign tx_cnt_o = '0;
    assign rx_cnt_o = '0;
`endif

endmodule
